multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RISC datapath: sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the 2-bit ALU_op consumed by the ALU control decoder, the mux selects and the register/memory/PC strobes.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter (wraps).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register; valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  PC load enable (branch condition already folded in).
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 0=rt, 1=rd.
- mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR.
- reg_write  output  1  register file write enable.
- ALU_src_A  output  1  0=PC, 1=A.
- ALU_src_B  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALU_op  output  2  00=add, 01=sub, 10=use func field.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  output  1  one-cycle pulse in the last state of each legal instruction.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- retired  output  RETIRE_W  count of completed instructions.
- state_dbg  output  4  current state encoding.

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000. All others are illegal.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Control outputs are a Moore decode of the state register, except pc_write and ir_write in FETCH and pc_write in BRANCH, which also depend on inputs.
- Any output not listed for a state is 0.
- Reset: state<=FETCH and retired<=0.
  - While reset=1, every strobe (pc_write, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op) is forced to 0.
  - Selects read 0 during reset.
  - Reset has priority over every transition, including mid-memory wait.
- FETCH: mem_read=1, IorD=0, ALU_src_A=0, ALU_src_B=01, ALU_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: ALU_src_A=0, ALU_src_B=11, ALU_op=00. Next state by opcode:
  - LW/SW -> MEM_ADDR.
  - R -> EXECUTE.
  - BEQ -> BRANCH.
  - J -> JUMP.
  - ADDI -> ADDI_EXEC.
  - Illegal: illegal_op=1, -> FETCH; retired is unchanged.
- MEM_ADDR: ALU_src_A=1, ALU_src_B=10, ALU_op=00. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_read=1, IorD=1. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEM_WRITE: mem_write=1, IorD=1. Hold until mem_ready=1; in that cycle instr_done=1 -> FETCH.
- EXECUTE: ALU_src_A=1, ALU_src_B=00, ALU_op=10 -> ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_op=01, pc_source=01, pc_write=zero, instr_done=1 -> FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1 -> FETCH.
- ADDI_EXEC: ALU_src_A=1, ALU_src_B=10, ALU_op=00 -> ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- Latency with mem_ready held at 1, in cycles:
  - R and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ and J: 3.
  - Each cycle mem_ready is low in a wait state adds one cycle.
- retired increments on every cycle instr_done=1 and wraps modulo 2^RETIRE_W.
- mem_read and mem_write are never high in the same cycle.
- Unused encodings 12-15 -> FETCH with all strobes 0.

Decomposition:
- Shared package holds:
  - opcode constants;
  - state enum (4-bit);
  - ALU_op codes ADD=00, SUB=01, FUNC=10;
  - ALU_src_B and pc_source encodings.
- One natural sub-module: ctrl_out_decode, a combinational state+inputs -> control-vector decode.
- The top level holds the state register, next-state logic and retire counter.

Test Plan:
- R-type, mem_ready=1 throughout, reset released -> states 0,1,6,7; ALU_op=10 in EXECUTE; reg_write=reg_dst=1 and instr_done=1 in ALU_WB; retired=1.
- LW with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read=IorD=1; MEM_WB asserts mem_to_reg=reg_write=1; total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 -> in BRANCH, ALU_op=01 and pc_source=01 both times; pc_write=1 only for the first; instr_done=1 for both.
- Opcode 111111 -> illegal_op pulses in DECODE; next state FETCH; retired unchanged; no reg_write or mem_write.
- SW in MEM_WRITE with mem_ready=0, reset asserted -> next cycle state=FETCH, mem_write=0 during reset, retired=0.
- 65536 J instructions with RETIRE_W=16 -> retired wraps to 0; each JUMP asserts pc_write=1 with pc_source=10.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RISC control path.
// Contents: supported opcodes, the 4-bit state enum, ALU_op codes,
// ALU_src_B / pc_source select encodings, the packed control vector and
// a legal-opcode helper.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       IorD;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_ctrl_out_decode.sv
// Combinational control-vector decode for the multi-cycle controller.
// Ports:
//   reset     - forces every strobe and select to 0 while high
//   state     - current FSM state
//   opcode    - instruction opcode (used for illegal detection in DECODE)
//   zero      - ALU zero flag (BEQ condition)
//   mem_ready - memory handshake (FETCH load strobes, SW completion)
//   ctrl      - full control vector
module ctrl_out_decode
  import multicycle_control_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        ST_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMM_SH2;
          ctrl.alu_op     = ALU_ADD;
          ctrl.illegal_op = !is_legal_op(opcode);
        end
        ST_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.IorD     = 1'b1;
        end
        ST_MEM_WB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        ST_MEM_WRITE: begin
          ctrl.mem_write  = 1'b1;
          ctrl.IorD       = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        ST_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_FUNC;
        end
        ST_ALU_WB: begin
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        ST_BRANCH: begin
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SRCB_B;
          ctrl.alu_op     = ALU_SUB;
          ctrl.pc_source  = PCSRC_ALUOUT;
          ctrl.pc_write   = zero;
          ctrl.instr_done = 1'b1;
        end
        ST_JUMP: begin
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.pc_write   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        ST_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_ADDI_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC datapath.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   opcode, zero          - instruction opcode and ALU zero flag
//   mem_ready             - memory completes current access this cycle
//   pc_write ... pc_source- datapath strobes and mux selects
//   instr_done            - pulse in the last state of each legal instruction
//   illegal_op            - pulse when DECODE sees an unsupported opcode
//   retired               - wrapping count of completed instructions
//   state_dbg             - current state encoding
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                IorD,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                ALU_src_A,
  output logic [1:0]          ALU_src_B,
  output logic [1:0]          ALU_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  ctrl_out_decode u_decode (
    .reset     (reset),
    .state     (state),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:     if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_R:         next_state = ST_EXECUTE;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
          OP_ADDI:      next_state = ST_ADDI_EXEC;
          default:      next_state = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) next_state = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) next_state = ST_FETCH;
      ST_EXECUTE:   next_state = ST_ALU_WB;
      ST_ADDI_EXEC: next_state = ST_ADDI_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                    next_state = ST_FETCH;
      default:      next_state = ST_FETCH;
    endcase
  end

  // instr_done from the decode is already gated by reset, so the counter
  // only needs reset to take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (ctrl.instr_done) retired <= retired + 1'b1;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign IorD       = ctrl.IorD;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign ALU_src_A  = ctrl.alu_src_a;
  assign ALU_src_B  = ctrl.alu_src_b;
  assign ALU_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state_dbg  = state;

endmodule
